// File: rtl/scope_trace_capture.sv
// scope_trace_capture
//   Acquisition front end for one oscilloscope channel. ADC samples are taken
//   on a decimated tick. A rising- or falling-edge trigger, or an auto-mode
//   timeout, starts the capture of one screen-width trace into an internal
//   buffer. The frame is held until the renderer acknowledges it.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   adc_data     unsigned ADC sample
//   decim        sample tick every decim clocks (0 behaves as 1)
//   trig_level   unsigned trigger threshold
//   trig_slope   0 = rising edge, 1 = falling edge
//   arm          level enable for acquisition
//   auto_mode    force a trigger after TIMEOUT ticks without one
//   frame_ack    one-cycle pulse: renderer has consumed the frame
//   rd_addr      column to read
//   rd_y         registered screen Y: full-scale minus sample, 0 past DEPTH
//   frame_ready  buffer holds a complete frame
//   capturing    capture in progress
//   forced_trig  current/last frame was started by the timeout
module scope_trace_capture #(
    parameter int SAMPLE_W = 8,
    parameter int DEPTH    = 1280,
    parameter int ADDR_W   = 11,
    parameter int TIMEOUT  = 4096
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic [7:0]          decim,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_slope,
    input  logic                arm,
    input  logic                auto_mode,
    input  logic                frame_ack,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [SAMPLE_W-1:0] rd_y,
    output logic                frame_ready,
    output logic                capturing,
    output logic                forced_trig
);

    localparam int               TO_W      = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // ------------------------------------------------------------------
    // Sample tick divider. div_max is reloaded only on the terminal count,
    // so a new decim value never truncates or stretches the period in flight.
    // ------------------------------------------------------------------
    logic [7:0] div_cnt;
    logic [7:0] div_max;
    logic [7:0] decim_eff;
    logic       tick;

    assign decim_eff = (decim == 8'd0) ? 8'd1 : decim;
    assign tick      = (div_cnt == div_max - 8'd1);

    // ------------------------------------------------------------------
    // Trigger detection and capture control
    // ------------------------------------------------------------------
    logic [SAMPLE_W-1:0] prev;
    logic                prev_valid;
    logic [TO_W-1:0]     to_cnt;
    logic [ADDR_W-1:0]   waddr;
    logic                rise_hit;
    logic                fall_hit;
    logic                trig_hit;
    logic                timeout_hit;
    logic                start_capture;
    logic                last_write;
    logic                enter_wait;

    assign rise_hit    = prev_valid && (prev < trig_level) && (adc_data >= trig_level);
    assign fall_hit    = prev_valid && (prev > trig_level) && (adc_data <= trig_level);
    assign trig_hit    = trig_slope ? fall_hit : rise_hit;
    assign timeout_hit = auto_mode && (to_cnt == TO_LAST);

    // arm=0 wins over a trigger arriving in the same cycle.
    assign start_capture = (state == WAIT_TRIG) && arm && tick && (trig_hit || timeout_hit);
    assign last_write    = (state == CAPTURE) && tick && (waddr == LAST_ADDR);
    assign enter_wait    = (state_nxt == WAIT_TRIG) && (state != WAIT_TRIG);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: a default assignment at the top of every combinational block
    // keeps each path fully specified, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (arm) state_nxt = WAIT_TRIG;
            end
            WAIT_TRIG: begin
                if (!arm)              state_nxt = IDLE;
                else if (start_capture) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (last_write) state_nxt = DONE;
            end
            DONE: begin
                if (frame_ack) state_nxt = arm ? WAIT_TRIG : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        capturing   = 1'b0;
        frame_ready = 1'b0;
        case (state)
            CAPTURE: capturing   = 1'b1;
            DONE:    frame_ready = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic rd_zero;

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt     <= 8'd0;
            div_max     <= decim_eff;
            prev        <= '0;
            prev_valid  <= 1'b0;
            to_cnt      <= '0;
            waddr       <= '0;
            forced_trig <= 1'b0;
            rd_zero     <= 1'b1;
        end else begin
            if (tick) begin
                div_cnt <= 8'd0;
                div_max <= decim_eff;
                prev    <= adc_data;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end

            // prev from before WAIT_TRIG is never compared against.
            if (enter_wait) begin
                prev_valid <= 1'b0;
            end else if (tick && (state == WAIT_TRIG)) begin
                prev_valid <= 1'b1;
            end

            if ((state != WAIT_TRIG) || !auto_mode || start_capture) begin
                to_cnt <= '0;
            end else if (tick) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            // buf[0] is written by the trigger tick itself, so CAPTURE starts at 1.
            if (start_capture) begin
                waddr       <= ADDR_W'(1);
                forced_trig <= !trig_hit;
            end else if ((state == CAPTURE) && tick) begin
                waddr <= waddr + ADDR_W'(1);
            end

            rd_zero <= (rd_addr > LAST_ADDR);
        end
    end

    // ------------------------------------------------------------------
    // Trace buffer: simple dual-port RAM, one write and one registered read.
    // ------------------------------------------------------------------
    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [SAMPLE_W-1:0] rd_raw;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [ADDR_W-1:0]   rd_idx;

    assign mem_we = !reset && (start_capture || ((state == CAPTURE) && tick));
    assign mem_wa = start_capture ? '0 : waddr;
    assign rd_idx = (rd_addr > LAST_ADDR) ? '0 : rd_addr;

    // NOTE: the buffer array has no reset so it maps onto block RAM; the
    // reset-cleared rd_zero flag is what forces rd_y to 0 out of reset.
    // A same-address read and write returns the old word.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_wa] <= adc_data;
        end
        rd_raw <= mem[rd_idx];
    end

    // Screen Y grows downward, so the stored sample is inverted.
    assign rd_y = rd_zero ? '0 : ~rd_raw;

endmodule

// File: tb/tb_scope_trace_capture.sv
// tb_scope_trace_capture
//   Directed stimulus for scope_trace_capture. A transaction-level model
//   (phase, tick period, timeout count, captured buffer) predicts the DUT
//   outputs; one process compares them every cycle, and the directed
//   sequence adds hand-computed literal checks.
module tb_scope_trace_capture;

    localparam int SAMPLE_W = 8;
    localparam int DEPTH    = 1280;
    localparam int ADDR_W   = 11;
    localparam int TIMEOUT  = 16;

    logic                clock = 1'b0;
    logic                reset;
    logic [SAMPLE_W-1:0] adc_data;
    logic [7:0]          decim;
    logic [SAMPLE_W-1:0] trig_level;
    logic                trig_slope;
    logic                arm;
    logic                auto_mode;
    logic                frame_ack;
    logic [ADDR_W-1:0]   rd_addr;
    logic [SAMPLE_W-1:0] rd_y;
    logic                frame_ready;
    logic                capturing;
    logic                forced_trig;

    scope_trace_capture #(
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .adc_data    (adc_data),
        .decim       (decim),
        .trig_level  (trig_level),
        .trig_slope  (trig_slope),
        .arm         (arm),
        .auto_mode   (auto_mode),
        .frame_ack   (frame_ack),
        .rd_addr     (rd_addr),
        .rd_y        (rd_y),
        .frame_ready (frame_ready),
        .capturing   (capturing),
        .forced_trig (forced_trig)
    );

    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef enum int {M_IDLE, M_WAIT, M_CAP, M_DONE} phase_t;

    phase_t m_phase     = M_IDLE;
    int     m_since     = 0;
    int     m_period    = 1;
    int     m_waits     = 0;
    int     m_windex    = 0;
    int     m_prev      = 0;
    bit     m_have_prev = 1'b0;
    bit     m_forced    = 1'b0;
    bit     m_rd_known  = 1'b0;
    int     m_rd_y      = 0;
    int     m_buf   [DEPTH];
    bit     m_valid [DEPTH];
    bit     chk_on      = 1'b0;

    always @(posedge clock) begin : model
        int period;
        bit is_tick;
        bit hit;
        period  = (decim == 8'd0) ? 1 : int'(decim);
        is_tick = (m_since + 1 == m_period);
        hit     = 1'b0;
        if (reset) begin
            m_phase     <= M_IDLE;
            m_since     <= 0;
            m_period    <= period;
            m_waits     <= 0;
            m_windex    <= 0;
            m_have_prev <= 1'b0;
            m_forced    <= 1'b0;
            m_rd_known  <= 1'b1;
            m_rd_y      <= 0;
        end else begin
            if (int'(rd_addr) >= DEPTH) begin
                m_rd_known <= 1'b1;
                m_rd_y     <= 0;
            end else begin
                m_rd_known <= m_valid[rd_addr];
                m_rd_y     <= 255 - m_buf[rd_addr];
            end

            if (is_tick) begin
                m_since  <= 0;
                m_period <= period;
            end else begin
                m_since <= m_since + 1;
            end

            case (m_phase)
                M_IDLE: begin
                    if (arm) begin
                        m_phase     <= M_WAIT;
                        m_have_prev <= 1'b0;
                        m_waits     <= 0;
                    end
                end
                M_WAIT: begin
                    if (!arm) begin
                        m_phase <= M_IDLE;
                    end else begin
                        if (!auto_mode) m_waits <= 0;
                        if (is_tick) begin
                            if (trig_slope)
                                hit = m_have_prev && (m_prev > int'(trig_level)) && (int'(adc_data) <= int'(trig_level));
                            else
                                hit = m_have_prev && (m_prev < int'(trig_level)) && (int'(adc_data) >= int'(trig_level));
                            if (hit || (auto_mode && m_waits == TIMEOUT - 1)) begin
                                m_buf[0]   <= int'(adc_data);
                                m_valid[0] <= 1'b1;
                                m_windex   <= 1;
                                m_forced   <= !hit;
                                m_phase    <= M_CAP;
                            end else if (auto_mode) begin
                                m_waits <= m_waits + 1;
                            end
                            m_prev      <= int'(adc_data);
                            m_have_prev <= 1'b1;
                        end
                    end
                end
                M_CAP: begin
                    if (is_tick) begin
                        m_buf[m_windex]   <= int'(adc_data);
                        m_valid[m_windex] <= 1'b1;
                        m_windex          <= m_windex + 1;
                        if (m_windex == DEPTH - 1) m_phase <= M_DONE;
                    end
                end
                M_DONE: begin
                    if (frame_ack) begin
                        if (arm) begin
                            m_phase     <= M_WAIT;
                            m_have_prev <= 1'b0;
                            m_waits     <= 0;
                        end else begin
                            m_phase <= M_IDLE;
                        end
                    end
                end
                default: m_phase <= M_IDLE;
            endcase
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clock) begin
        if (chk_on) begin
            check("frame_ready", int'(frame_ready), int'(m_phase == M_DONE));
            check("capturing",   int'(capturing),   int'(m_phase == M_CAP));
            check("forced_trig", int'(forced_trig), int'(m_forced));
            if (m_rd_known) check("rd_y", int'(rd_y), m_rd_y);
        end
    end

    task automatic sweep();
        for (int a = 0; a < DEPTH + 2; a++) begin
            rd_addr = ADDR_W'(a);
            @(negedge clock);
        end
    endtask

    task automatic read_at(input int addr, input int expected, input string name);
        rd_addr = ADDR_W'(addr);
        @(negedge clock);
        check(name, int'(rd_y), expected);
    endtask

    int n;
    int m;
    int v;
    int trig_val;
    bit saw_cap;

    initial begin
        reset      = 1'b1;
        arm        = 1'b0;
        auto_mode  = 1'b0;
        frame_ack  = 1'b0;
        decim      = 8'd1;
        trig_level = 8'd128;
        trig_slope = 1'b0;
        adc_data   = 8'd0;
        rd_addr    = ADDR_W'(DEPTH);

        // 1: reset and idle
        repeat (2) @(negedge clock);
        chk_on = 1'b1;
        check("reset rd_y", int'(rd_y), 0);
        check("reset frame_ready", int'(frame_ready), 0);
        check("reset capturing", int'(capturing), 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            adc_data = 8'(i * 37);
            @(negedge clock);
            check("idle frame_ready", int'(frame_ready), 0);
            check("idle capturing", int'(capturing), 0);
            check("idle rd_y", int'(rd_y), 0);
        end

        // 2: rising trigger on a ramp, decim=1
        arm = 1'b1; adc_data = 8'd100;
        @(negedge clock); adc_data = 8'd110;
        @(negedge clock); adc_data = 8'd120;
        @(negedge clock); adc_data = 8'd130;
        n = 0;
        while (!frame_ready && n < 3000) begin
            @(negedge clock);
            n++;
            if (n == 1) check("t2 capturing after trigger", int'(capturing), 1);
            adc_data = 8'(n * 3);
        end
        check("t2 frame_ready latency", n, DEPTH);
        check("t2 forced_trig", int'(forced_trig), 0);
        read_at(0, 125, "t2 rd_y[0]");
        sweep();

        // 6: ack with arm=1, prev_valid cleared, ack ignored in WAIT_TRIG
        adc_data  = 8'd0;
        frame_ack = 1'b1;
        @(negedge clock);
        frame_ack = 1'b0;
        check("t6 frame_ready cleared", int'(frame_ready), 0);
        adc_data = 8'd200;
        @(negedge clock);
        check("t6 no trigger on first tick", int'(capturing), 0);
        repeat (3) @(negedge clock);
        frame_ack = 1'b1;
        @(negedge clock);
        frame_ack = 1'b0;
        check("t6 ack in wait frame_ready", int'(frame_ready), 0);
        check("t6 ack in wait capturing", int'(capturing), 0);
        repeat (3) @(negedge clock);
        check("t6 still waiting", int'(capturing), 0);
        arm = 1'b0;
        @(negedge clock);

        // 3: falling trigger, decim=4
        decim = 8'd4; trig_level = 8'd50; trig_slope = 1'b1; adc_data = 8'd60;
        repeat (8) @(negedge clock);
        arm = 1'b1;
        repeat (12) @(negedge clock);
        adc_data = 8'd40;
        n = 0;
        while (!capturing && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("t3 trigger within one tick", int'(n >= 1 && n <= 4), 1);
        m = 0;
        while (!frame_ready && m < 6000) begin
            @(negedge clock);
            m++;
        end
        check("t3 capture length at decim 4", m, 4 * (DEPTH - 1));
        check("t3 forced_trig", int'(forced_trig), 0);
        read_at(0, 215, "t3 rd_y[0]");
        read_at(DEPTH - 1, 215, "t3 rd_y[last]");
        read_at(DEPTH, 0, "t3 rd_y out of range");
        read_at(2047, 0, "t3 rd_y max addr");
        arm = 1'b0; frame_ack = 1'b1;
        @(negedge clock);
        frame_ack = 1'b0;
        check("t3 ack to idle", int'(frame_ready), 0);

        // 4: auto-mode forced trigger
        decim = 8'd1; auto_mode = 1'b1; trig_level = 8'd128; trig_slope = 1'b0; adc_data = 8'd7;
        repeat (8) @(negedge clock);
        arm = 1'b1;
        n = 0;
        while (!capturing && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("t4 forced trigger latency", n, TIMEOUT + 1);
        check("t4 forced_trig", int'(forced_trig), 1);
        m = 0;
        while (!frame_ready && m < 3000) begin
            @(negedge clock);
            m++;
        end
        check("t4 frame_ready", int'(frame_ready), 1);
        read_at(0, 248, "t4 rd_y[0]");
        read_at(640, 248, "t4 rd_y[640]");
        read_at(DEPTH - 1, 248, "t4 rd_y[last]");
        arm = 1'b0; frame_ack = 1'b1;
        @(negedge clock);
        frame_ack = 1'b0;

        // 4b: same stimulus without auto_mode never starts
        auto_mode = 1'b0; arm = 1'b1; saw_cap = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (capturing) saw_cap = 1'b1;
        end
        check("t4b no capture without auto", int'(saw_cap), 0);
        check("t4b forced_trig holds", int'(forced_trig), 1);
        arm = 1'b0;
        @(negedge clock);

        // 5: reset mid-capture, then restart at buf[0]
        auto_mode = 1'b1; trig_level = 8'd0; trig_slope = 1'b0; rd_addr = ADDR_W'(5);
        v = 1; adc_data = 8'(v); arm = 1'b1;
        n = 0;
        while (!capturing && n < 100) begin
            @(negedge clock);
            n++;
            v = v + 5; adc_data = 8'(v);
        end
        for (int k = 1; k < 600; k++) begin
            @(negedge clock);
            v = v + 5; adc_data = 8'(v);
        end
        reset = 1'b1; arm = 1'b0;
        @(negedge clock);
        check("t5 capturing after reset", int'(capturing), 0);
        check("t5 frame_ready after reset", int'(frame_ready), 0);
        check("t5 forced_trig after reset", int'(forced_trig), 0);
        reset = 1'b0;
        @(negedge clock);
        v = 11; adc_data = 8'(v); arm = 1'b1;
        n = 0;
        while (!capturing && n < 100) begin
            @(negedge clock);
            n++;
            if (!capturing) begin
                v = v + 7; adc_data = 8'(v);
            end
        end
        trig_val = int'(adc_data);
        check("t5 re-arm forced latency", n, TIMEOUT + 1);
        m = 0;
        while (!frame_ready && m < 3000) begin
            @(negedge clock);
            m++;
            v = v + 7; adc_data = 8'(v);
        end
        check("t5 frame_ready after restart", int'(frame_ready), 1);
        read_at(0, 255 - trig_val, "t5 rd_y[0] restart");
        sweep();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
